// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: size codes, FSM states and
// read/write polarity.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational size/address decode for big-endian byte lanes. Lane k is the
// byte at addr_al+k. Honours MISALIGN_ABORT_EN (fault instead of force-align).
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  input  logic [31:0]       rd_lanes,
  output logic [ADDR_W-1:0] addr_al,
  output logic [3:0]        lane_we,
  output logic [31:0]       wr_lanes,
  output logic [31:0]       rd_data,
  output logic              fault
);

  always_comb begin
    addr_al  = addr;
    lane_we  = 4'b0000;
    wr_lanes = '0;
    rd_data  = '0;
    fault    = 1'b0;
    case (size)
      SZ_BYTE: begin
        lane_we  = 4'b0001;
        wr_lanes = {wr_data[7:0], 24'h0};
        rd_data  = {24'h0, rd_lanes[31:24]};
      end
      SZ_HALF: begin
        addr_al  = {addr[ADDR_W-1:1], 1'b0};
        lane_we  = 4'b0011;
        wr_lanes = {wr_data[15:0], 16'h0};
        rd_data  = {16'h0, rd_lanes[31:16]};
`ifdef MISALIGN_ABORT_EN
        fault    = addr[0];
`endif
      end
      SZ_WORD: begin
        addr_al  = {addr[ADDR_W-1:2], 2'b00};
        lane_we  = 4'b1111;
        wr_lanes = wr_data;
        rd_data  = rd_lanes;
`ifdef MISALIGN_ABORT_EN
        fault    = |addr[1:0];
`endif
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a request, waits WAIT_CYCLES, performs a
// big-endian byte-addressed RAM access and raises mfc. Option: MISALIGN_ABORT_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mfc,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mfc_q, mfc_d;
  logic              err_q, err_d;
  logic [31:0]       dout_q, dout_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [7:0]        mem_q [DEPTH];

  logic [ADDR_W-1:0] addr_al;
  logic [3:0]        lane_we;
  logic [31:0]       wr_lanes, rd_lanes, rd_data;
  logic              fault, access, do_write;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W];

  mem_lane_align #(.ADDR_W(ADDR_W)) u_align (
    .size    (size_q),
    .addr    (addr_q),
    .wr_data (din_q),
    .rd_lanes(rd_lanes),
    .addr_al (addr_al),
    .lane_we (lane_we),
    .wr_lanes(wr_lanes),
    .rd_data (rd_data),
    .fault   (fault)
  );

  // Four consecutive bytes starting at the aligned address, wrapping in RAM.
  always_comb begin
    rd_lanes = '0;
    for (int k = 0; k < 4; k++) begin
      rd_lanes[31-8*k -: 8] = mem_q[addr_al + ADDR_W'(k)];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mfc_d    = mfc_q;
    err_d    = err_q;
    dout_d   = dout_q;
    rw_d     = rw_q;
    size_d   = size_q;
    addr_d   = addr_q;
    din_d    = din_q;
    access   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mov) begin
          rw_d    = rw;
          size_d  = size;
          addr_d  = addr[ADDR_W-1:0];
          din_d   = data_in;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mov) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_DONE;
          mfc_d   = 1'b1;
          err_d   = fault;
          if (fault)                 dout_d = '0;
          else if (rw_q == RW_READ)  dout_d = rd_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!mov) begin
          mfc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    do_write = access & ~fault & (rw_q == RW_WRITE) & ~rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Request holding registers and RAM are data only; reset leaves them alone.
  always_ff @(posedge clk) begin
    rw_q   <= rw_d;
    size_q <= size_d;
    addr_q <= addr_d;
    din_q  <= din_d;
    if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we[k]) mem_q[addr_al + ADDR_W'(k)] <= wr_lanes[31-8*k -: 8];
      end
    end
  end

  assign data_out = dout_q;
  assign mfc      = mfc_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a transaction-level
// model of a byte-array RAM with big-endian access.
module tb_mem_responder;

  localparam int ADDR_W = 9;
  localparam int WAITC  = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst, mov, rw;
  logic [1:0]  size;
  logic [31:0] addr, data_in, data_out;
  logic        mfc, busy, err;

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst), .mov(mov), .rw(rw), .size(size), .addr(addr),
    .data_in(data_in), .data_out(data_out), .mfc(mfc), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mm [DEPTH];
  bit          m_busy, m_done, chk_en;
  int          m_age;
  logic        m_rw;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_din;
  logic        exp_err;
  logic [31:0] exp_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_complete();
    int n;
    int base;
    bit flt;
    n   = (m_size == 2'b00) ? 1 : (m_size == 2'b01) ? 2 : 4;
    flt = (m_size == 2'b11);
`ifdef MISALIGN_ABORT_EN
    if (!flt && (int'(m_addr[1:0]) % n) != 0) flt = 1'b1;
`endif
    base = int'(m_addr[ADDR_W-1:0]);
    base = base - (base % n);
    m_done  = 1'b1;
    exp_err = flt;
    if (flt) begin
      exp_dout = 32'h0;
    end else if (m_rw) begin
      exp_dout = 32'h0;
      for (int k = 0; k < n; k++) exp_dout = (exp_dout << 8) | {24'h0, mm[(base + k) % DEPTH]};
    end else begin
      for (int k = 0; k < n; k++) mm[(base + k) % DEPTH] = m_din[8*(n-1-k) +: 8];
    end
  endfunction

  function automatic void model_reset();
    m_busy   = 1'b0;
    m_done   = 1'b0;
    exp_err  = 1'b0;
    exp_dout = 32'h0;
  endfunction

  // One clock edge: advance the model using the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (mov) begin
        m_busy = 1'b1; m_age = 0;
        m_rw = rw; m_size = size; m_addr = addr; m_din = data_in;
      end
    end else if (!m_done) begin
      if (!mov) m_busy = 1'b0;
      else begin
        m_age++;
        if (m_age == WAITC + 1) model_complete();
      end
    end else if (!mov) begin
      m_busy = 1'b0; m_done = 1'b0; exp_err = 1'b0;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mfc", {31'h0, mfc}, {31'h0, m_done});
      check("busy", {31'h0, busy}, {31'h0, m_busy});
      check("data_out", data_out, exp_dout);
      if (m_done) check("err", {31'h0, err}, {31'h0, exp_err});
    end
  end

  task automatic op(input logic r, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                    input int hold, output logic [31:0] q, output logic e, output int lat);
    int n;
    n = 0;
    mov = 1'b1; rw = r; size = s; addr = a; data_in = d;
    do begin
      tick();
      n++;
      if (n == 1) begin
        rw = 1'($urandom); size = 2'($urandom); addr = $urandom; data_in = $urandom;
      end
    end while (!mfc && n < 40);
    lat = n - 1;
    if (!mfc) check("mfc_timeout", {31'h0, mfc}, 32'h1);
    repeat (hold) tick();
    q = data_out;
    e = err;
    mov = 1'b0;
    tick();
  endtask

  task automatic abort_op(input logic [31:0] a, input logic [31:0] d, input int k);
    mov = 1'b1; rw = 1'b0; size = 2'b00; addr = a; data_in = d;
    tick();
    repeat (k) tick();
    mov = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] q;
    logic        e;
    int          lat;
    rst = 1'b1; mov = 1'b0; rw = 1'b0; size = 2'b00; addr = 32'h0; data_in = 32'h0;
    chk_en = 1'b0;
    model_reset();
    #12;
    check("reset_data_out", data_out, 32'h0);
    check("reset_mfc", {31'h0, mfc}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < DEPTH; i += 4) op(1'b0, 2'b10, 32'(i), 32'h0, 0, q, e, lat);

    op(1'b0, 2'b10, 32'h010, 32'hDEADBEEF, 0, q, e, lat);
    op(1'b1, 2'b10, 32'h010, 32'h0, 0, q, e, lat);
    check("word_read", q, 32'hDEADBEEF);
    check("word_latency", 32'(lat), 32'd3);
    op(1'b1, 2'b00, 32'h010, 32'h0, 1, q, e, lat);
    check("byte_read_010", q, 32'h000000DE);
    op(1'b1, 2'b00, 32'h013, 32'h0, 0, q, e, lat);
    check("byte_read_013", q, 32'h000000EF);

    op(1'b0, 2'b01, 32'h022, 32'hFFFF1234, 0, q, e, lat);
    op(1'b0, 2'b00, 32'h021, 32'hFFFFFFAB, 0, q, e, lat);
    op(1'b1, 2'b10, 32'h020, 32'h0, 0, q, e, lat);
    check("lanes_word_020", q, 32'h00AB1234);

    op(1'b0, 2'b00, 32'h030, 32'h77, 0, q, e, lat);
    abort_op(32'h030, 32'h55, 1);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_mfc", {31'h0, mfc}, 32'h0);
    op(1'b1, 2'b00, 32'h030, 32'h0, 0, q, e, lat);
    check("abort_ram_kept", q, 32'h77);

    mov = 1'b1; rw = 1'b0; size = 2'b00; addr = 32'h030; data_in = 32'h99;
    tick();
    tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_mfc", {31'h0, mfc}, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    check("async_rst_err", {31'h0, err}, 32'h0);
    check("async_rst_data_out", data_out, 32'h0);
    tick();
    rst = 1'b0; mov = 1'b0;
    tick();
    op(1'b1, 2'b00, 32'h030, 32'h0, 0, q, e, lat);
    check("rst_ram_kept", q, 32'h77);

    op(1'b0, 2'b10, 32'h040, 32'hCAFEF00D, 0, q, e, lat);
    op(1'b1, 2'b10, 32'h041, 32'h0, 0, q, e, lat);
`ifdef MISALIGN_ABORT_EN
    check("misalign_data", q, 32'h0);
    check("misalign_err", {31'h0, e}, 32'h1);
`else
    check("misalign_data", q, 32'hCAFEF00D);
    check("misalign_err", {31'h0, e}, 32'h0);
`endif

    op(1'b1, 2'b11, 32'h050, 32'h0, 3, q, e, lat);
    check("rsvd_data", q, 32'h0);
    check("rsvd_err_held", {31'h0, e}, 32'h1);
    check("rsvd_mfc_cleared", {31'h0, mfc}, 32'h0);
    check("rsvd_err_cleared", {31'h0, err}, 32'h0);

    repeat (300) begin
      if ($urandom_range(0, 7) == 0)
        abort_op($urandom, $urandom, int'($urandom_range(0, WAITC)));
      else
        op(1'($urandom), 2'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)), q, e, lat);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
